// File: rtl/cnt_pkg.sv
// Shared constants and types for the counter library blocks.
// Default widths match the accumulator so snapshot streams line up without adaptation.
package cnt_pkg;

  localparam int CNT_DW = 8;
  localparam int CNT_CW = 16;

  typedef struct packed {
    logic valid;
    logic first;
  } hs_status_t;

endpackage

// File: rtl/hs_pipe_reg.sv
// Single-entry valid/ready register slice with synchronous clear.
// Accepts a new beat in the same cycle the held one drains, so throughput stays at one per cycle.
module hs_pipe_reg #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  assign in_ready = !rst && !clr && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/accum_diff.sv
// First-difference stage: turns a stream of accumulated values back into per-interval increments.
// Re-accumulating out_data reproduces in_data exactly, modulo 2^DW.
module accum_diff
  import cnt_pkg::*;
#(
  parameter int DW = CNT_DW,
  parameter int CW = CNT_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_first,
  output logic [CW-1:0] nsamp
);

  logic [DW-1:0] prev;
  logic          first_pend;
  logic [DW-1:0] diff;
  logic          accept;
  logic [DW:0]   pipe_in;
  logic [DW:0]   pipe_out;

  assign diff    = in_data - prev;
  assign accept  = in_valid && in_ready;
  assign pipe_in = {first_pend, diff};

  hs_pipe_reg #(.PW(DW + 1)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pipe_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pipe_out)
  );

  assign out_first = pipe_out[DW];
  assign out_data  = pipe_out[DW-1:0];

  // History is what the next difference is taken against; first sample diffs against zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      first_pend <= 1'b1;
      nsamp      <= '0;
    end else if (clr) begin
      prev       <= '0;
      first_pend <= 1'b1;
      nsamp      <= '0;
    end else if (accept) begin
      prev       <= in_data;
      first_pend <= 1'b0;
      if (nsamp != {CW{1'b1}})
        nsamp <= nsamp + 1'b1;
    end
  end

endmodule

// File: tb/tb_accum_diff.sv
// Self-checking bench for accum_diff: directed scenarios plus a randomized
// round trip through a behavioural accumulator, with a CW=4 copy for saturation.
module tb_accum_diff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, out_valid, out_first;
  logic [7:0]  out_data;
  logic [15:0] nsamp;
  logic        in_ready4, out_valid4, out_first4;
  logic [7:0]  out_data4;
  logic [3:0]  nsamp4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accum_diff #(.DW(8), .CW(16)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .nsamp(nsamp)
  );

  accum_diff #(.DW(8), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_first(out_first4), .nsamp(nsamp4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    in_valid = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (out_first !== 1'b0) begin failures++; $display("FAIL reset_out_first got=%b exp=0", out_first); end
    checks++; if (nsamp !== 16'd0) begin failures++; $display("FAIL reset_nsamp got=%0d exp=0", nsamp); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_stream();
    logic [7:0] smp [4];
    logic [7:0] exp [4];
    smp = '{8'd5, 8'd12, 8'd12, 8'd40};
    exp = '{8'd5, 8'd7, 8'd0, 8'd28};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = smp[i];
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid%0d got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== exp[i]) begin failures++; $display("FAIL stream_data%0d got=%0d exp=%0d", i, out_data, exp[i]); end
      checks++; if (out_first !== (i == 0)) begin failures++; $display("FAIL stream_first%0d got=%b exp=%b", i, out_first, (i == 0)); end
    end
    in_valid = 1'b0;
    checks++; if (nsamp !== 16'd4) begin failures++; $display("FAIL stream_nsamp got=%0d exp=4", nsamp); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    in_valid = 1'b0;
    clr = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL wrap_clr_ready got=%b exp=0", in_ready); end
    step();
    clr = 1'b0;
    checks++; if (nsamp !== 16'd0) begin failures++; $display("FAIL wrap_clr_nsamp got=%0d exp=0", nsamp); end
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd250;
    step();
    checks++; if (out_data !== 8'd250 || out_first !== 1'b1) begin failures++; $display("FAIL wrap_first got=%0d/%b exp=250/1", out_data, out_first); end
    in_data = 8'd4;
    step();
    checks++; if (out_data !== 8'd10 || out_first !== 1'b0) begin failures++; $display("FAIL wrap_diff got=%0d/%b exp=10/0", out_data, out_first); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    clr_pulse();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd1;
    step();
    checks++; if (out_data !== 8'd1 || out_first !== 1'b1) begin failures++; $display("FAIL bp_first got=%0d/%b exp=1/1", out_data, out_first); end
    out_ready = 1'b0;
    in_data = 8'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'd1) begin failures++; $display("FAIL bp_hold%0d got=%b/%0d exp=1/1", i, out_valid, out_data); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d got=%b exp=0", i, in_ready); end
      checks++; if (nsamp !== 16'd1) begin failures++; $display("FAIL bp_nsamp%0d got=%0d exp=1", i, nsamp); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    checks++; if (out_data !== 8'd2 || out_first !== 1'b0) begin failures++; $display("FAIL bp_second got=%0d/%b exp=2/0", out_data, out_first); end
    in_data = 8'd9;
    step();
    checks++; if (out_data !== 8'd6 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_third got=%0d/%b exp=6/1", out_data, out_valid); end
    in_valid = 1'b0;
    checks++; if (nsamp !== 16'd3) begin failures++; $display("FAIL bp_nsamp got=%0d exp=3", nsamp); end
    step();
  endtask

  task automatic test_clr();
    clr_pulse();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd10;
    step();
    in_data = 8'd30;
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'd20) begin failures++; $display("FAIL clr_pending got=%b/%0d exp=1/20", out_valid, out_data); end
    in_valid = 1'b0;
    clr = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clr_ready got=%b exp=0", in_ready); end
    step();
    clr = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_drop got=%b exp=0", out_valid); end
    checks++; if (nsamp !== 16'd0) begin failures++; $display("FAIL clr_nsamp0 got=%0d exp=0", nsamp); end
    in_valid = 1'b1;
    in_data = 8'd7;
    step();
    checks++; if (out_data !== 8'd7 || out_first !== 1'b1) begin failures++; $display("FAIL clr_next got=%0d/%b exp=7/1", out_data, out_first); end
    checks++; if (nsamp !== 16'd1) begin failures++; $display("FAIL clr_nsamp1 got=%0d exp=1", nsamp); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_async_rst();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd50;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    checks++; if (nsamp !== 16'd0) begin failures++; $display("FAIL arst_nsamp got=%0d exp=0", nsamp); end
    checks++; if (out_first !== 1'b0) begin failures++; $display("FAIL arst_first got=%b exp=0", out_first); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b exp=0", in_ready); end
    #2;
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd3;
    step();
    checks++; if (out_data !== 8'd3 || out_first !== 1'b1) begin failures++; $display("FAIL arst_next got=%0d/%b exp=3/1", out_data, out_first); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_round_trip();
    logic [7:0] q[$];
    logic [7:0] acc;
    logic [7:0] exp;
    int  cnt;
    int  out_cnt;
    bit  hold;
    clr_pulse();
    acc = '0;
    cnt = 0;
    out_cnt = 0;
    hold = 1'b0;
    for (int cyc = 0; cyc < 20000 && cnt < 1000; cyc++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++; if (nsamp !== 16'(cnt)) begin failures++; $display("FAIL rt_nsamp got=%0d exp=%0d", nsamp, cnt); end
      checks++; if (nsamp4 !== ((cnt > 15) ? 4'd15 : 4'(cnt))) begin failures++; $display("FAIL rt_nsamp4 got=%0d exp=%0d", nsamp4, (cnt > 15) ? 15 : cnt); end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL rt_spurious got=%0d exp=none", out_data);
        end else begin
          exp = q.pop_front();
          acc = acc + out_data;
          if (acc !== exp) begin failures++; $display("FAIL rt_accum n=%0d got=%0d exp=%0d", out_cnt, acc, exp); end
        end
        checks++; if (out_first !== (out_cnt == 0)) begin failures++; $display("FAIL rt_first n=%0d got=%b exp=%b", out_cnt, out_first, (out_cnt == 0)); end
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        cnt++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (cnt != 1000) begin failures++; $display("FAIL rt_budget got=%0d exp=1000", cnt); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
      if (out_valid) begin
        exp = q.pop_front();
        acc = acc + out_data;
        checks++; if (acc !== exp) begin failures++; $display("FAIL rt_drain got=%0d exp=%0d", acc, exp); end
      end
      @(posedge clk);
      #1;
    end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rt_leftover got=%0d exp=0", q.size()); end
    checks++; if (nsamp !== 16'd1000) begin failures++; $display("FAIL rt_nsamp_final got=%0d exp=1000", nsamp); end
    checks++; if (nsamp4 !== 4'd15) begin failures++; $display("FAIL rt_nsamp4_sat got=%0d exp=15", nsamp4); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_backpressure();
    test_clr();
    test_async_rst();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accum_diff.md
Name: accum_diff

Overview:
- Inverse of the running accumulator in the counter library. Accepts a stream of accumulated values and emits first differences, so that re-accumulating the outputs reproduces the input exactly (mod 2^DW).
- Sits between a counter/accumulator snapshot source and downstream consumers that need per-interval increments.
- Valid/ready handshake on both sides; one registered output stage.

Parameters:
- DW, 8, data width of accumulated input and difference output.
- CW, 16, width of the saturating sample counter.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous reset, active-high
- clr  input  1  synchronous clear of history/state
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept input
- in_data  input  DW  accumulated value
- out_valid  output  1  difference valid
- out_ready  input  1  downstream accepts difference
- out_data  output  DW  in_data minus previous accepted in_data, mod 2^DW
- out_first  output  1  marks first difference after reset/clr (computed against 0)
- nsamp  output  CW  count of input samples accepted since reset/clr, saturating

Behaviour:
- Reset (rst=1, async): prev=0, out_valid=0, out_data=0, out_first=0, nsamp=0, first_pend=1. in_ready=0 while rst is high.
- in_ready = !clr && (!out_valid || out_ready). This is combinational and gives a full-throughput single-entry pipeline.
- Input handshake: in_valid && in_ready. On a handshake, at the next edge:
  - out_data <= in_data - prev (DW-bit wrap, no carry/borrow out)
  - out_first <= first_pend
  - out_valid <= 1
  - prev <= in_data
  - first_pend <= 0
  - nsamp <= nsamp+1, saturating at 2^CW-1
- Output handshake: out_valid && out_ready. If no input handshake occurs in the same cycle, out_valid <= 0. out_data and out_first hold their values; they are don't-care once invalid.
- Backpressure: while out_valid && !out_ready, all output regs hold, in_ready=0, and prev/nsamp hold.
- Latency: 1 cycle from input handshake to out_valid. Throughput is 1 sample/cycle when out_ready=1.
- First sample: prev=0, so out_data=in_data and out_first=1.
- Wrap-around: in_data < prev yields the modular difference, e.g. DW=8, prev=250, in=4 -> out=10.
- clr=1 (synchronous, priority over everything):
  - prev <= 0, first_pend <= 1, nsamp <= 0, out_valid <= 0.
  - Any pending output is dropped.
  - in_ready=0 that cycle, so no input is consumed.
- clr together with out_ready: the output is discarded; the downstream must not treat that cycle as a transfer. The bench must treat out_valid as qualified only when clr=0.
- rst asserted mid-stream: state returns to reset values immediately; the next accepted sample is treated as first.
- in_data must stay stable while in_valid && !in_ready. The block does not check this.

Decomposition:
- Shared package cnt_pkg: default width constants (CNT_DW=8, CNT_CW=16) and the typedef for the handshake status {valid, first}. These are shared with the accumulator and other counter blocks.
- One natural sub-module: hs_pipe_reg. A single-entry valid/ready register slice with a clr input and parameterized payload width. It carries {out_first, out_data}.
- accum_diff owns the prev register, the subtractor, first_pend and the nsamp counter.

Test Plan:
- Reset then stream 5,12,12,40 with out_ready=1 -> outputs 5(first=1),7,0,28 on consecutive cycles; nsamp=4.
- Wrap: DW=8, stream 250 then 4 -> outputs 250(first=1) then 10.
- Backpressure: hold out_ready=0 for 3 cycles after the first output. Required: out_data stable, in_ready=0, no sample lost; on release, the remaining outputs appear in order.
- clr mid-stream: after 10,30 are accepted, pulse clr while out_valid=1, then send 7.
  - Required: the pending output (20) is dropped and in_ready=0 during clr.
  - Next output is 7 with out_first=1; nsamp=1.
- Async rst asserted between clock edges while out_valid=1 -> out_valid, nsamp and out_first go to 0 immediately; the next sample 3 gives out 3 with first=1.
- Round-trip: random 1000-sample stream with random valid/ready, fed into the existing accumulator (en=out_valid&&out_ready) -> accumulator output equals the corresponding input sample every time; nsamp saturates correctly when run with CW=4.
